// File: rtl/lsu_st_seq.sv
// lsu_st_seq -- LSU store sequencer feeding the AXI write interface.
//
// Accepts one strided store command, issues a single AW request carrying the
// stride code and burst count, then streams every W beat out of the on-chip
// ORAM through a 2-entry skid buffer. B responses are counted; when the last
// beat is sent and every expected response has arrived, st_done pulses once.
//
// Optional feature (macro LSU_ST_BRESP_CHK_EN):
//   defined   -> st_err is sticky on any non-OKAY counted response; the tag of
//                the first failing response is exported on err_oram_addr.
//   undefined -> st_err is tied low, bresp/tag are ignored, no err_oram_addr.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_*                      store command (valid/ready + burst fields)
//   lsu_axi_aw*, axi_lsu_awrdy AW request channel
//   lsu_axi_w*, axi_lsu_wrdy   W beat channel (strobe always all ones)
//   axi_lsu_b*, lsu_axi_brdy   B response channel (always ready)
//   lsu_oram_rd_*, oram_lsu_rd_data  ORAM read port, data 1 cycle after rd_en
//   st_done, st_err            completion pulse, sticky error
module lsu_st_seq #(
    parameter int DATA_W  = 64,
    parameter int ORAM_AW = 12,
    parameter int AXI_AW  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic [AXI_AW-1:0]    cmd_awaddr,
    input  logic [7:0]           cmd_awlen,
    input  logic [2:0]           cmd_awsize,
    input  logic [2:0]           cmd_awstr,
    input  logic [3:0]           cmd_awnum,
    input  logic [ORAM_AW-1:0]   cmd_oram_addr,
    output logic [7:0]           lsu_axi_awid,
    output logic [AXI_AW-1:0]    lsu_axi_awaddr,
    output logic [7:0]           lsu_axi_awlen,
    output logic [2:0]           lsu_axi_awsize,
    output logic [1:0]           lsu_axi_awburst,
    output logic [2:0]           lsu_axi_awstr,
    output logic [3:0]           lsu_axi_awnum,
    output logic [ORAM_AW-1:0]   lsu_axi_oram_addr,
    output logic                 lsu_axi_awvld,
    input  logic                 axi_lsu_awrdy,
    output logic [DATA_W-1:0]    lsu_axi_wdata,
    output logic [DATA_W/8-1:0]  lsu_axi_wstrb,
    output logic                 lsu_axi_wlast,
    output logic                 lsu_axi_wvld,
    input  logic                 axi_lsu_wrdy,
    input  logic                 axi_lsu_bvld,
    input  logic [1:0]           axi_lsu_bresp,
    input  logic [ORAM_AW-1:0]   axi_lsu_resp_oram_addr,
    output logic                 lsu_axi_brdy,
    output logic                 lsu_oram_rd_en,
    output logic [ORAM_AW-1:0]   lsu_oram_rd_addr,
    input  logic [DATA_W-1:0]    oram_lsu_rd_data,
    output logic                 st_done,
    output logic                 st_err
`ifdef LSU_ST_BRESP_CHK_EN
    ,
    output logic [ORAM_AW-1:0]   err_oram_addr
`endif
);

    typedef enum logic [2:0] {IDLE, AW, DATA, WAITB, DONE} state_t;
    state_t state;

    logic [7:0]         id_cnt;
    logic [11:0]        total_beats;
    logic [4:0]         bursts_exp;
    logic [4:0]         b_cnt;
    logic [11:0]        rd_cnt;
    logic [11:0]        wr_cnt;
    logic [7:0]         beat_cnt;
    logic [ORAM_AW-1:0] rd_addr;
    logic               rd_inflight;
    logic [DATA_W-1:0]  skid [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         skid_occ;

    logic               cmd_acc;
    logic               aw_fire;
    logic               w_fire;
    logic               b_fire;
    logic               last_beat;
    logic [4:0]         b_cnt_nxt;
    logic [11:0]        total_nxt;
    logic [2:0]         occ_after;

    assign cmd_acc   = cmd_vld & cmd_rdy;
    assign aw_fire   = lsu_axi_awvld & axi_lsu_awrdy;
    assign w_fire    = lsu_axi_wvld & axi_lsu_wrdy;
    assign b_fire    = axi_lsu_bvld & lsu_axi_brdy;
    assign b_cnt_nxt = b_cnt + {4'd0, b_fire};
    assign last_beat = w_fire && (wr_cnt == total_beats - 12'd1);
    assign total_nxt = ({4'd0, cmd_awlen} + 12'd1) * ({8'd0, cmd_awnum} + 12'd1);

    // Slots that will be held after this cycle: the beat leaving now frees
    // its slot, which is what lets a full-rate stream run without bubbles.
    assign occ_after = {1'b0, skid_occ} + {2'd0, rd_inflight} - {2'd0, w_fire};

    assign lsu_oram_rd_en   = (state == DATA) && (rd_cnt != total_beats) && (occ_after < 3'd2);
    assign lsu_oram_rd_addr = rd_addr;
    assign lsu_axi_wvld     = (state == DATA) && (skid_occ != 2'd0);
    assign lsu_axi_wdata    = skid[rd_ptr];
    assign lsu_axi_wstrb    = '1;
    assign lsu_axi_wlast    = lsu_axi_wvld && (beat_cnt == lsu_axi_awlen);
    assign lsu_axi_brdy     = 1'b1;

    // Control FSM with registered AW fields, cmd_rdy and st_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cmd_rdy           <= 1'b1;
            st_done           <= 1'b0;
            lsu_axi_awvld     <= 1'b0;
            lsu_axi_awid      <= '0;
            lsu_axi_awaddr    <= '0;
            lsu_axi_awlen     <= '0;
            lsu_axi_awsize    <= '0;
            lsu_axi_awburst   <= '0;
            lsu_axi_awstr     <= '0;
            lsu_axi_awnum     <= '0;
            lsu_axi_oram_addr <= '0;
            id_cnt            <= '0;
            total_beats       <= '0;
            bursts_exp        <= '0;
            b_cnt             <= '0;
        end else begin
            st_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Responses seen here belong to nothing and are dropped.
                    if (cmd_acc) begin
                        state             <= AW;
                        cmd_rdy           <= 1'b0;
                        lsu_axi_awvld     <= 1'b1;
                        lsu_axi_awid      <= id_cnt;
                        lsu_axi_awaddr    <= cmd_awaddr;
                        lsu_axi_awlen     <= cmd_awlen;
                        lsu_axi_awsize    <= cmd_awsize;
                        lsu_axi_awburst   <= 2'b01;
                        lsu_axi_awstr     <= cmd_awstr;
                        lsu_axi_awnum     <= cmd_awnum;
                        lsu_axi_oram_addr <= cmd_oram_addr;
                        id_cnt            <= id_cnt + 8'd1;
                        total_beats       <= total_nxt;
                        bursts_exp        <= {1'b0, cmd_awnum} + 5'd1;
                        b_cnt             <= '0;
                    end
                end
                AW: begin
                    b_cnt <= b_cnt_nxt;
                    if (aw_fire) begin
                        lsu_axi_awvld <= 1'b0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    b_cnt <= b_cnt_nxt;
                    if (last_beat) begin
                        if (b_cnt_nxt == bursts_exp) begin
                            state   <= DONE;
                            st_done <= 1'b1;
                        end else begin
                            state <= WAITB;
                        end
                    end
                end
                WAITB: begin
                    b_cnt <= b_cnt_nxt;
                    if (b_cnt_nxt == bursts_exp) begin
                        state   <= DONE;
                        st_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cmd_rdy <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ORAM read issue, skid buffer fill/drain and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            beat_cnt    <= '0;
            rd_inflight <= 1'b0;
            skid[0]     <= '0;
            skid[1]     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            skid_occ    <= '0;
        end else begin
            rd_inflight <= lsu_oram_rd_en;
            if (cmd_acc) begin
                rd_addr  <= cmd_oram_addr;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (lsu_oram_rd_en) begin
                    rd_addr <= rd_addr + ORAM_AW'(1);
                    rd_cnt  <= rd_cnt + 12'd1;
                end
                if (w_fire) begin
                    wr_cnt   <= wr_cnt + 12'd1;
                    beat_cnt <= lsu_axi_wlast ? 8'd0 : beat_cnt + 8'd1;
                end
            end
            if (rd_inflight) begin
                skid[wr_ptr] <= oram_lsu_rd_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (w_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            skid_occ <= skid_occ + {1'b0, rd_inflight} - {1'b0, w_fire};
        end
    end

`ifdef LSU_ST_BRESP_CHK_EN
    // Sticky error; the tag of the first failing response is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_err        <= 1'b0;
            err_oram_addr <= '0;
        end else if (cmd_acc) begin
            st_err <= 1'b0;
        end else if ((state != IDLE) && b_fire && (axi_lsu_bresp != 2'b00)) begin
            st_err <= 1'b1;
            if (!st_err) begin
                err_oram_addr <= axi_lsu_resp_oram_addr;
            end
        end
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^{axi_lsu_bresp, axi_lsu_resp_oram_addr};
    assign st_err       = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_st_seq.sv
module tb_lsu_st_seq;
    localparam int DATA_W  = 64;
    localparam int ORAM_AW = 12;
    localparam int AXI_AW  = 10;

    logic                clk;
    logic                rst_n;
    logic                cmd_vld;
    logic                cmd_rdy;
    logic [AXI_AW-1:0]   cmd_awaddr;
    logic [7:0]          cmd_awlen;
    logic [2:0]          cmd_awsize;
    logic [2:0]          cmd_awstr;
    logic [3:0]          cmd_awnum;
    logic [ORAM_AW-1:0]  cmd_oram_addr;
    logic [7:0]          lsu_axi_awid;
    logic [AXI_AW-1:0]   lsu_axi_awaddr;
    logic [7:0]          lsu_axi_awlen;
    logic [2:0]          lsu_axi_awsize;
    logic [1:0]          lsu_axi_awburst;
    logic [2:0]          lsu_axi_awstr;
    logic [3:0]          lsu_axi_awnum;
    logic [ORAM_AW-1:0]  lsu_axi_oram_addr;
    logic                lsu_axi_awvld;
    logic                axi_lsu_awrdy;
    logic [DATA_W-1:0]   lsu_axi_wdata;
    logic [DATA_W/8-1:0] lsu_axi_wstrb;
    logic                lsu_axi_wlast;
    logic                lsu_axi_wvld;
    logic                axi_lsu_wrdy;
    logic                axi_lsu_bvld;
    logic [1:0]          axi_lsu_bresp;
    logic [ORAM_AW-1:0]  axi_lsu_resp_oram_addr;
    logic                lsu_axi_brdy;
    logic                lsu_oram_rd_en;
    logic [ORAM_AW-1:0]  lsu_oram_rd_addr;
    logic [DATA_W-1:0]   oram_lsu_rd_data;
    logic                st_done;
    logic                st_err;
`ifdef LSU_ST_BRESP_CHK_EN
    logic [ORAM_AW-1:0]  err_oram_addr;
`endif

    lsu_st_seq #(.DATA_W(DATA_W), .ORAM_AW(ORAM_AW), .AXI_AW(AXI_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_awaddr(cmd_awaddr), .cmd_awlen(cmd_awlen), .cmd_awsize(cmd_awsize),
        .cmd_awstr(cmd_awstr), .cmd_awnum(cmd_awnum), .cmd_oram_addr(cmd_oram_addr),
        .lsu_axi_awid(lsu_axi_awid), .lsu_axi_awaddr(lsu_axi_awaddr),
        .lsu_axi_awlen(lsu_axi_awlen), .lsu_axi_awsize(lsu_axi_awsize),
        .lsu_axi_awburst(lsu_axi_awburst), .lsu_axi_awstr(lsu_axi_awstr),
        .lsu_axi_awnum(lsu_axi_awnum), .lsu_axi_oram_addr(lsu_axi_oram_addr),
        .lsu_axi_awvld(lsu_axi_awvld), .axi_lsu_awrdy(axi_lsu_awrdy),
        .lsu_axi_wdata(lsu_axi_wdata), .lsu_axi_wstrb(lsu_axi_wstrb),
        .lsu_axi_wlast(lsu_axi_wlast), .lsu_axi_wvld(lsu_axi_wvld),
        .axi_lsu_wrdy(axi_lsu_wrdy),
        .axi_lsu_bvld(axi_lsu_bvld), .axi_lsu_bresp(axi_lsu_bresp),
        .axi_lsu_resp_oram_addr(axi_lsu_resp_oram_addr), .lsu_axi_brdy(lsu_axi_brdy),
        .lsu_oram_rd_en(lsu_oram_rd_en), .lsu_oram_rd_addr(lsu_oram_rd_addr),
        .oram_lsu_rd_data(oram_lsu_rd_data),
        .st_done(st_done), .st_err(st_err)
`ifdef LSU_ST_BRESP_CHK_EN
        , .err_oram_addr(err_oram_addr)
`endif
    );

    // Scoreboard counters
    int n_cmp = 0;
    int n_err = 0;

    // Environment state: written only by the responder process
    int                cyc = 0;
    int                nb = 0;
    int                rd_n = 0;
    int                done_cnt = 0;
    int                done_cyc = 0;
    int                b_hs = 0;
    int                b_at_done = 0;
    int                b_pend = 0;
    int                outst = 0;
    int                max_outst = 0;
    logic              b_last = 1'b0;
    logic              rd_pend = 1'b0;
    logic [11:0]       rd_pend_addr = '0;
    logic [63:0]       wd [256];
    logic              wl [256];
    int                wc [256];
    logic [11:0]       rd_log [256];

    // Environment controls: written only by the main sequence
    int                wr_mode = 0;
    int                stall_start = 1000000;
    logic              b_same = 1'b0;
    logic [1:0]        b_code = 2'b00;
    logic [11:0]       b_tag = '0;

    function automatic logic [63:0] oram_f(input logic [11:0] a);
        return {16'h5A5A, 4'h0, a, 20'h0, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ORAM model, W-ready pattern, B responder and channel monitor.
    initial begin
        axi_lsu_wrdy = 1'b0;
        axi_lsu_bvld = 1'b0;
        axi_lsu_bresp = 2'b00;
        axi_lsu_resp_oram_addr = '0;
        oram_lsu_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rd_pend) oram_lsu_rd_data = oram_f(rd_pend_addr);
            rd_pend = 1'b0;
            if (wr_mode == 0) axi_lsu_wrdy = 1'b1;
            else axi_lsu_wrdy = (cyc % 2 == 1) && !(cyc >= stall_start && cyc < stall_start + 5);
            axi_lsu_bvld = 1'b0;
            if (b_pend > 0 && !b_last) begin
                axi_lsu_bvld = 1'b1;
                axi_lsu_bresp = b_code;
                axi_lsu_resp_oram_addr = b_tag;
                b_pend--;
            end
            b_last = axi_lsu_bvld;
            @(negedge clk);
            if (!rst_n) begin
                outst = 0;
            end else begin
                if (st_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    b_at_done = b_hs;
                end
                if (axi_lsu_bvld && lsu_axi_brdy) b_hs++;
                if (lsu_oram_rd_en) begin
                    rd_log[rd_n % 256] = lsu_oram_rd_addr;
                    rd_n++;
                    rd_pend = 1'b1;
                    rd_pend_addr = lsu_oram_rd_addr;
                    outst++;
                end
                if (lsu_axi_wvld && axi_lsu_wrdy) begin
                    wd[nb % 256] = lsu_axi_wdata;
                    wl[nb % 256] = lsu_axi_wlast;
                    wc[nb % 256] = cyc;
                    nb++;
                    outst--;
                    if (lsu_axi_wlast) begin
                        if (b_same) begin
                            axi_lsu_bvld = 1'b1;
                            axi_lsu_bresp = b_code;
                            axi_lsu_resp_oram_addr = b_tag;
                            b_hs++;
                        end else begin
                            b_pend++;
                        end
                    end
                end
                if (outst > max_outst) max_outst = outst;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [9:0] aa, input logic [7:0] len, input logic [2:0] sz,
                            input logic [2:0] str, input logic [3:0] num, input logic [11:0] ob,
                            input logic [7:0] exp_id);
        tick();
        cmd_vld = 1'b1;
        cmd_awaddr = aa; cmd_awlen = len; cmd_awsize = sz;
        cmd_awstr = str; cmd_awnum = num; cmd_oram_addr = ob;
        smp();
        chk("cmd_rdy_idle", 64'(cmd_rdy), 64'd1);
        tick();
        cmd_vld = 1'b0;
        smp();
        chk("awvld_set", 64'(lsu_axi_awvld), 64'd1);
        chk("cmd_rdy_busy", 64'(cmd_rdy), 64'd0);
        chk("awid", 64'(lsu_axi_awid), 64'(exp_id));
        chk("awaddr", 64'(lsu_axi_awaddr), 64'(aa));
        chk("awlen", 64'(lsu_axi_awlen), 64'(len));
        chk("awsize", 64'(lsu_axi_awsize), 64'(sz));
        chk("awburst", 64'(lsu_axi_awburst), 64'd1);
        chk("awstr", 64'(lsu_axi_awstr), 64'(str));
        chk("awnum", 64'(lsu_axi_awnum), 64'(num));
        chk("aw_oram_addr", 64'(lsu_axi_oram_addr), 64'(ob));
        smp();
        chk("awvld_hold", 64'(lsu_axi_awvld), 64'd1);
        chk("awaddr_hold", 64'(lsu_axi_awaddr), 64'(aa));
        tick();
        axi_lsu_awrdy = 1'b1;
        tick();
        axi_lsu_awrdy = 1'b0;
        smp();
        chk("awvld_drop", 64'(lsu_axi_awvld), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k;
        for (k = 0; k < 400 && done_cnt == d0; k++) smp();
        chk(tag, 64'(done_cnt - d0), 64'd1);
        smp();
        smp();
        chk("done_one_cycle", 64'(done_cnt - d0), 64'd1);
        chk("cmd_rdy_after", 64'(cmd_rdy), 64'd1);
    endtask

    task automatic check_beats(input int nb0, input logic [11:0] base, input int n,
                               input logic [15:0] last_mask);
        logic [15:0] got_mask;
        chk("beat_count", 64'(nb - nb0), 64'(n));
        got_mask = '0;
        for (int i = 0; i < n; i++) begin
            chk("wdata", wd[(nb0 + i) % 256], oram_f(base + 12'(i)));
            got_mask[i] = wl[(nb0 + i) % 256];
        end
        chk("wlast_pattern", 64'(got_mask), 64'(last_mask));
    endtask

    initial begin
        int d0, b0, n0, r0, k;
        rst_n = 1'b0;
        cmd_vld = 1'b0;
        cmd_awaddr = '0; cmd_awlen = '0; cmd_awsize = '0;
        cmd_awstr = '0; cmd_awnum = '0; cmd_oram_addr = '0;
        axi_lsu_awrdy = 1'b0;
        smp();
        smp();
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_awvld", 64'(lsu_axi_awvld), 64'd0);
        chk("rst_wvld", 64'(lsu_axi_wvld), 64'd0);
        chk("rst_rd_en", 64'(lsu_oram_rd_en), 64'd0);
        chk("rst_st_done", 64'(st_done), 64'd0);
        chk("rst_st_err", 64'(st_err), 64'd0);
        chk("rst_brdy", 64'(lsu_axi_brdy), 64'd1);
        chk("rst_awaddr", 64'(lsu_axi_awaddr), 64'd0);
        rst_n = 1'b1;
        smp();

        // Single burst, full-rate stream
        d0 = done_cnt; n0 = nb; r0 = rd_n;
        send_cmd(10'h100, 8'd3, 3'd3, 3'd0, 4'd0, 12'h010, 8'd0);
        wait_done("t1_done", d0);
        check_beats(n0, 12'h010, 4, 16'b1000);
        chk("t1_zero_bubble", 64'(wc[(n0 + 3) % 256] - wc[n0 % 256]), 64'd3);
        chk("t1_rd_count", 64'(rd_n - r0), 64'd4);
        chk("t1_rd_addr0", 64'(rd_log[r0 % 256]), 64'h010);
        chk("t1_rd_addr3", 64'(rd_log[(r0 + 3) % 256]), 64'h013);
        chk("wstrb", 64'(lsu_axi_wstrb), 64'hFF);

        // Strided multi-burst: done only after the third B
        d0 = done_cnt; n0 = nb; b0 = b_hs;
        send_cmd(10'h040, 8'd1, 3'd3, 3'd1, 4'd2, 12'h020, 8'd1);
        wait_done("t2_done", d0);
        check_beats(n0, 12'h020, 6, 16'b101010);
        chk("t2_b_before_done", 64'(b_at_done - b0), 64'd3);

        // Backpressure: toggling ready with a 5-cycle stall
        wr_mode = 1;
        stall_start = cyc + 9;
        d0 = done_cnt; n0 = nb;
        send_cmd(10'h080, 8'd7, 3'd3, 3'd2, 4'd0, 12'h040, 8'd2);
        wait_done("t3_done", d0);
        check_beats(n0, 12'h040, 8, 16'b1000_0000);
        chk("t3_skid_bound", 64'(max_outst <= 2), 64'd1);
        wr_mode = 0;

        // ORAM address wrap
        d0 = done_cnt; n0 = nb; r0 = rd_n;
        send_cmd(10'h000, 8'd3, 3'd3, 3'd0, 4'd0, 12'hFFE, 8'd3);
        wait_done("t4_done", d0);
        check_beats(n0, 12'hFFE, 4, 16'b1000);
        chk("t4_rd_addr0", 64'(rd_log[r0 % 256]), 64'hFFE);
        chk("t4_rd_addr1", 64'(rd_log[(r0 + 1) % 256]), 64'hFFF);
        chk("t4_rd_addr2", 64'(rd_log[(r0 + 2) % 256]), 64'h000);
        chk("t4_rd_addr3", 64'(rd_log[(r0 + 3) % 256]), 64'h001);

        // SLVERR B in the same cycle as the final beat
        b_same = 1'b1; b_code = 2'b10; b_tag = 12'h0AB;
        d0 = done_cnt; n0 = nb;
        send_cmd(10'h010, 8'd1, 3'd3, 3'd0, 4'd0, 12'h080, 8'd4);
        wait_done("t5_done", d0);
        check_beats(n0, 12'h080, 2, 16'b10);
        chk("t5_direct_done", 64'(done_cyc - wc[(n0 + 1) % 256]), 64'd1);
`ifdef LSU_ST_BRESP_CHK_EN
        chk("t5_st_err", 64'(st_err), 64'd1);
        chk("t5_err_addr", 64'(err_oram_addr), 64'h0AB);
`else
        chk("t5_st_err_off", 64'(st_err), 64'd0);
`endif
        b_same = 1'b0; b_code = 2'b00; b_tag = '0;

        // Reset in the middle of DATA
        n0 = nb;
        send_cmd(10'h020, 8'd7, 3'd3, 3'd0, 4'd0, 12'h100, 8'd5);
        chk("t6_err_cleared", 64'(st_err), 64'd0);
        for (k = 0; k < 50 && (nb - n0) < 2; k++) smp();
        chk("t6_two_beats", 64'(nb - n0 >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("t6_rst_awvld", 64'(lsu_axi_awvld), 64'd0);
        chk("t6_rst_wvld", 64'(lsu_axi_wvld), 64'd0);
        chk("t6_rst_rd_en", 64'(lsu_oram_rd_en), 64'd0);
        chk("t6_rst_awid", 64'(lsu_axi_awid), 64'd0);
        chk("t6_rst_wdata", lsu_axi_wdata, 64'd0);
        chk("t6_rst_st_done", 64'(st_done), 64'd0);
        smp();
        smp();
        rst_n = 1'b1;
        smp();
        d0 = done_cnt; n0 = nb;
        send_cmd(10'h030, 8'd1, 3'd3, 3'd0, 4'd0, 12'h200, 8'd0);
        wait_done("t7_done", d0);
        check_beats(n0, 12'h200, 2, 16'b10);
        chk("skid_bound_all", 64'(max_outst <= 2), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lsu_st_seq.md
Name: lsu_st_seq

Overview:
- LSU store sequencer, directly upstream of the AXI write interface.
- Accepts one strided store command, issues a single AW request carrying the stride/count, and streams every W beat from the on-chip ORAM through a 2-entry skid buffer.
- Counts B responses and reports completion and error to the LSU control FSM.

Parameters:
- DATA_W, 64, W beat width and ORAM read width.
- ORAM_AW, 12, ORAM address width.
- AXI_AW, 10, AXI address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  store command valid
- cmd_rdy  out  1  sequencer idle, command accepted when cmd_vld&cmd_rdy
- cmd_awaddr  in  AXI_AW  first burst address
- cmd_awlen  in  8  beats per burst minus 1
- cmd_awsize  in  3  AXI size
- cmd_awstr  in  3  stride code, passed through
- cmd_awnum  in  4  bursts minus 1
- cmd_oram_addr  in  ORAM_AW  ORAM source base address
- lsu_axi_awid / awaddr / awlen / awsize / awburst / awstr / awnum / oram_addr  out  8/AXI_AW/8/3/2/3/4/ORAM_AW  AW request fields
- lsu_axi_awvld  out  1  AW request valid
- axi_lsu_awrdy  in  1  AW ready
- lsu_axi_wdata  out  DATA_W  beat data
- lsu_axi_wstrb  out  DATA_W/8  beat strobe
- lsu_axi_wlast  out  1  last beat of burst
- lsu_axi_wvld  out  1  beat valid
- axi_lsu_wrdy  in  1  beat ready
- axi_lsu_bvld  in  1  response valid
- axi_lsu_bresp  in  2  response code
- axi_lsu_resp_oram_addr  in  ORAM_AW  response tag
- lsu_axi_brdy  out  1  response ready
- lsu_oram_rd_en  out  1  ORAM read strobe
- lsu_oram_rd_addr  out  ORAM_AW  ORAM read address
- oram_lsu_rd_data  in  DATA_W  ORAM data, valid 1 cycle after rd_en
- st_done  out  1  one-cycle completion pulse
- st_err  out  1  sticky error, cleared on next command accept

Behaviour:
- Reset values:
  - cmd_rdy=1.
  - All *_vld=0, lsu_oram_rd_en=0, st_done=0, st_err=0.
  - lsu_axi_brdy=1.
  - All data/address registers 0.
  - FSM in IDLE.
- FSM states: IDLE, AW, DATA, WAITB, DONE.
- IDLE -> AW on command accept.
  - Latch all cmd fields.
  - total_beats=(awlen+1)*(awnum+1), held as a 12-bit product.
  - bursts_exp=awnum+1, held in 5 bits.
  - lsu_axi_awburst=2'b01 (INCR).
  - lsu_axi_awid = 8-bit counter, incremented per command, wraps 255->0.
- AW state:
  - lsu_axi_awvld=1, with all fields stable until axi_lsu_awrdy.
  - AW->DATA on handshake; awvld drops the following cycle.
- DATA state:
  - ORAM read address starts at the base and increments by 1 per rd_en, wrapping 4095->0.
  - rd_en is asserted only if (skid occupancy + reads in flight) < 2 and beats remain to be read.
  - Returned data is written into the skid buffer; its head drives lsu_axi_wdata.
  - lsu_axi_wstrb is all ones.
  - Beat counter: 8 bits, counts 0..awlen.
  - lsu_axi_wlast=1 when beat counter == awlen; the counter returns to 0 after the wlast handshake.
  - No beat is lost or duplicated when wrdy is deasserted for any duration.
  - Zero-bubble streaming is required when wrdy is held high.
  - DATA->WAITB when the final beat handshakes.
- B responses:
  - Counted in any non-IDLE state whenever axi_lsu_bvld&lsu_axi_brdy; a response may arrive in the same cycle as the last beat.
  - WAITB->DONE when bresp count == bursts_exp, which can also occur in the same cycle DATA completes; that transition goes directly to DONE.
  - Responses arriving in IDLE are acknowledged and dropped.
- DONE: st_done=1 for exactly one cycle, then IDLE. cmd_rdy=1 only in IDLE.
- Asynchronous reset mid-operation: immediate return to reset values; skid buffer and counters cleared; in-flight ORAM data ignored.

Optional Feature:
- LSU_ST_BRESP_CHK_EN defined:
  - st_err sets when any counted bresp != 2'b00.
  - The axi_lsu_resp_oram_addr of the first failing response is held on internal register err_oram_addr, exported as an extra output port err_oram_addr [ORAM_AW].
- Not defined:
  - st_err tied 0, err_oram_addr port absent.
  - bresp ignored, responses only counted.

Test Plan:
- Single burst: awlen=3, awnum=0, base ORAM 0x010, wrdy=1, one OKAY B -> 1 AW; 4 beats of ORAM[0x010..0x013] on consecutive cycles; wlast on beat 3; st_done pulse; awid increments.
- Strided multi-burst: awlen=1, awnum=2, awstr=1 -> 1 AW with awnum=2; 6 beats with wlast on beats 1, 3, 5; done after the 3rd B, not before.
- Backpressure: awlen=7, wrdy toggling 1/0 each cycle plus a 5-cycle stall -> data sequence exactly ORAM[base..base+7]; rd_en never overruns the skid buffer.
- ORAM wrap: base 0xFFE, awlen=3 -> read addresses FFE, FFF, 000, 001.
- Simultaneous events and error: B arrives in the same cycle as the final beat handshake, with bresp=2'b10 -> DONE reached; with LSU_ST_BRESP_CHK_EN, st_err=1 and err_oram_addr captured; st_err clears on next accept.
- Reset mid-DATA after 2 of 8 beats -> all outputs return to reset values, cmd_rdy=1, next command runs cleanly.
